// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
//
// Frame-based scan controller for the 16-bit 16x1 voice mux. A sample tick
// starts a frame. The frame visits every enabled channel in ascending order:
// the block drives the mux select, waits SETTLE_CYCLES full cycles, captures
// the mux output and then offers the word downstream on a valid/ready
// handshake. This block is the only master of the mux select lines.
//
// Parameters
//   SETTLE_CYCLES    : cycles the select is held stable before capture (1..15)
//
// Ports
//   i_clock          : system clock, rising-edge active
//   i_reset_n        : asynchronous active-low reset
//   i_sample_tick    : one-cycle strobe that starts a frame
//   i_channel_enable : per-channel enable mask, latched at frame start
//   o_select         : mux select
//   i_mux_data       : mux output word
//   o_data           : captured word
//   o_channel        : channel index of o_data
//   o_valid          : o_data/o_channel valid
//   i_ready          : consumer accepts the word
//   o_busy           : frame in progress
//   o_frame_done     : one-cycle pulse when a frame completes
//   o_overrun        : one-cycle pulse when a tick arrives while busy
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_sample_tick,
  input  logic [15:0] i_channel_enable,
  output logic [3:0]  o_select,
  input  logic [15:0] i_mux_data,
  output logic [15:0] o_data,
  output logic [3:0]  o_channel,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_overrun
);

  localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [15:0] r_mask;
  logic [3:0]  r_settleCount;
  logic [3:0]  r_select;
  logic [15:0] r_data;
  logic [3:0]  r_channel;
  logic        r_valid;
  logic        r_frameDone;
  logic        r_overrun;

  logic [3:0]  w_firstChannel;
  logic [3:0]  w_nextChannel;
  logic        w_hasNext;
  logic        w_transfer;
  logic        w_settleDone;
  logic        w_maskNonZero;

  // Lowest enabled channel of the live mask; only used on the tick that
  // starts a frame. Scanning downward lets the lowest set bit win.
  always_comb begin
    w_firstChannel = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (i_channel_enable[i]) begin
        w_firstChannel = 4'(i);
      end
    end
  end

  // Next enabled channel strictly above the current select in the latched
  // mask. No wrap: if nothing remains above, the frame ends.
  always_comb begin
    w_nextChannel = 4'd0;
    w_hasNext     = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_select))) begin
        w_nextChannel = 4'(i);
        w_hasNext     = 1'b1;
      end
    end
  end

  assign w_transfer    = r_valid & i_ready;
  assign w_maskNonZero = (i_channel_enable != 16'd0);
  // The counter is loaded with SETTLE_CYCLES and the capture happens on the
  // edge that would take it to zero, so a count of 1 means "capture now".
  assign w_settleDone  = (r_settleCount <= 4'd1);

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_sample_tick && w_maskNonZero) begin
          w_stateNext = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_settleDone) begin
          w_stateNext = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (w_transfer) begin
          w_stateNext = w_hasNext ? ST_SETTLE : ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Datapath: mask latch, select, settle counter, capture register and the
  // status pulses. A tick that arrives while a frame is running is dropped
  // and only reported through the overrun pulse.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mask        <= 16'd0;
      r_settleCount <= 4'd0;
      r_select      <= 4'd0;
      r_data        <= 16'd0;
      r_channel     <= 4'd0;
      r_valid       <= 1'b0;
      r_frameDone   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      r_overrun   <= i_sample_tick && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (i_sample_tick) begin
            if (w_maskNonZero) begin
              r_mask        <= i_channel_enable;
              r_select      <= w_firstChannel;
              r_settleCount <= LP_SETTLE_LOAD;
            end else begin
              // Empty frame: report completion without any transfer.
              r_frameDone <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (w_settleDone) begin
            r_data        <= i_mux_data;
            r_channel     <= r_select;
            r_valid       <= 1'b1;
            r_settleCount <= 4'd0;
          end else begin
            r_settleCount <= r_settleCount - 4'd1;
          end
        end
        ST_OUTPUT: begin
          if (w_transfer) begin
            r_valid <= 1'b0;
            if (w_hasNext) begin
              r_select      <= w_nextChannel;
              r_settleCount <= LP_SETTLE_LOAD;
            end else begin
              r_frameDone <= 1'b1;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_select     = r_select;
  assign o_data       = r_data;
  assign o_channel    = r_channel;
  assign o_valid      = r_valid;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_frameDone;
  assign o_overrun    = r_overrun;

  // Handshake guarantees: a stalled word never disappears and never changes.
  a_validHolds : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    (r_valid && !i_ready) |=> r_valid);

  a_wordStable : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    (r_valid && !i_ready) |=> ($stable(r_data) && $stable(r_channel) && $stable(r_select)));

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_sequencer
//
// Two sequencers (SETTLE_CYCLES = 1 and 3) share the same tick, mask, ready
// and reset stimulus. Each mux is modelled as data = {4{select}}. A
// transaction-level reference model (a list of channels per frame plus the
// absolute edge at which each capture is due) predicts every output after
// every edge. On top of that: a table of whole-frame records, hand-written
// corner sequences, and a randomized run.
// -----------------------------------------------------------------------------
module tb_mux_scan_sequencer;

  logic        clock = 1'b0;
  logic        rstN;
  logic        iTick;
  logic [15:0] iMask;
  logic        iReady;

  logic [3:0]  sel      [2];
  logic [15:0] muxData  [2];
  logic [15:0] data     [2];
  logic [3:0]  chan     [2];
  logic        valid    [2];
  logic        busy     [2];
  logic        done     [2];
  logic        overrun  [2];

  int testsRun    = 0;
  int testsFailed = 0;
  int edgeNum     = 0;

  // Reference model state, one slot per DUT.
  int settleOf [2] = '{1, 3};
  bit mBusy    [2];
  bit mValid   [2];
  bit mDone    [2];
  bit mOverrun [2];
  int mSel     [2];
  int mData    [2];
  int mChan    [2];
  int mCap     [2];
  int chanCount[2];
  int chanPos  [2];
  int chanList [2][16];

  typedef struct {
    logic [15:0] mask;
    int          expCount;
    int          expFirst;
    int          expLast;
    int          expSum;
    int          expDoneEdge;
  } frameVec_t;

  frameVec_t vecs [6];

  // Free-running clock.
  always #5 clock = ~clock;

  // Each mux returns its select replicated into every nibble.
  assign muxData[0] = {4{sel[0]}};
  assign muxData[1] = {4{sel[1]}};

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) dutFast (
    .i_clock          (clock),
    .i_reset_n        (rstN),
    .i_sample_tick    (iTick),
    .i_channel_enable (iMask),
    .o_select         (sel[0]),
    .i_mux_data       (muxData[0]),
    .o_data           (data[0]),
    .o_channel        (chan[0]),
    .o_valid          (valid[0]),
    .i_ready          (iReady),
    .o_busy           (busy[0]),
    .o_frame_done     (done[0]),
    .o_overrun        (overrun[0])
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(3)) dutSlow (
    .i_clock          (clock),
    .i_reset_n        (rstN),
    .i_sample_tick    (iTick),
    .i_channel_enable (iMask),
    .o_select         (sel[1]),
    .i_mux_data       (muxData[1]),
    .o_data           (data[1]),
    .o_channel        (chan[1]),
    .o_valid          (valid[1]),
    .i_ready          (iReady),
    .o_busy           (busy[1]),
    .o_frame_done     (done[1]),
    .o_overrun        (overrun[1])
  );

  // One comparison: counts it and reports a failure.
  task automatic compareValue(input string name, input int k, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s dut%0d edge %0d: got %0h expected %0h", name, k, edgeNum, actual, expected);
    end
  endtask

  task automatic modelResetOne(input int k);
    mBusy[k]     = 1'b0;
    mValid[k]    = 1'b0;
    mDone[k]     = 1'b0;
    mOverrun[k]  = 1'b0;
    mSel[k]      = 0;
    mData[k]     = 0;
    mChan[k]     = 0;
    mCap[k]      = 0;
    chanCount[k] = 0;
    chanPos[k]   = 0;
  endtask

  // Predicts the effect of the coming edge from the inputs applied before it.
  task automatic modelStep(input int k, input int edgeNext);
    mDone[k]    = 1'b0;
    mOverrun[k] = 1'b0;
    if (mBusy[k]) begin
      if (iTick) mOverrun[k] = 1'b1;
      if (mValid[k]) begin
        if (iReady) begin
          mValid[k] = 1'b0;
          chanPos[k] = chanPos[k] + 1;
          if (chanPos[k] < chanCount[k]) begin
            mSel[k] = chanList[k][chanPos[k]];
            mCap[k] = edgeNext + settleOf[k];
          end else begin
            mBusy[k] = 1'b0;
            mDone[k] = 1'b1;
          end
        end
      end else if (edgeNext == mCap[k]) begin
        mValid[k] = 1'b1;
        mData[k]  = mSel[k] * 'h1111;
        mChan[k]  = mSel[k];
      end
    end else if (iTick) begin
      if (iMask == 16'd0) begin
        mDone[k] = 1'b1;
      end else begin
        chanCount[k] = 0;
        for (int ch = 0; ch < 16; ch++) begin
          if (iMask[ch]) begin
            chanList[k][chanCount[k]] = ch;
            chanCount[k] = chanCount[k] + 1;
          end
        end
        chanPos[k] = 0;
        mSel[k]    = chanList[k][0];
        mCap[k]    = edgeNext + settleOf[k];
        mBusy[k]   = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      compareValue("o_valid",      k, int'(valid[k]),   int'(mValid[k]));
      compareValue("o_busy",       k, int'(busy[k]),    int'(mBusy[k]));
      compareValue("o_frame_done", k, int'(done[k]),    int'(mDone[k]));
      compareValue("o_overrun",    k, int'(overrun[k]), int'(mOverrun[k]));
      compareValue("o_select",     k, int'(sel[k]),     mSel[k]);
      compareValue("o_data",       k, int'(data[k]),    mData[k]);
      compareValue("o_channel",    k, int'(chan[k]),    mChan[k]);
    end
  endtask

  // Drives inputs for one cycle (called at a falling edge), advances the
  // model over the rising edge and checks outputs at the next falling edge.
  task automatic applyStimulus(input logic tick, input logic [15:0] mask, input logic ready);
    iTick  = tick;
    iMask  = mask;
    iReady = ready;
    for (int k = 0; k < 2; k++) begin
      if (!rstN) modelResetOne(k);
      else       modelStep(k, edgeNum + 1);
    end
    @(negedge clock);
    edgeNum++;
    checkOutput();
  endtask

  // Asynchronous reset in the middle of a low clock phase.
  task automatic assertReset();
    rstN = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) modelResetOne(k);
    checkOutput();
  endtask

  task automatic drainIdle();
    for (int n = 0; n < 400 && (busy[0] || busy[1]); n++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1);
    end
    compareValue("drainTimeout", 0, int'(busy[0] | busy[1]), 0);
  endtask

  initial begin
    int rel, cnt, sum, first, last, n, ovCount;
    logic [15:0] rmask;

    vecs[0] = '{16'hFFFF, 16,  0, 15, 120, 32};
    vecs[1] = '{16'h8421,  4,  0, 15,  30,  8};
    vecs[2] = '{16'h0000,  0, -1, -1,   0,  0};
    vecs[3] = '{16'h0001,  1,  0,  0,   0,  2};
    vecs[4] = '{16'h8000,  1, 15, 15,  15,  2};
    vecs[5] = '{16'h00C0,  2,  6,  7,  13,  4};

    rstN   = 1'b0;
    iTick  = 1'b0;
    iMask  = 16'h0000;
    iReady = 1'b0;
    for (int k = 0; k < 2; k++) modelResetOne(k);
    @(negedge clock);

    // Reset held with random inputs, then released with no tick.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'($urandom), 1'b1);

    // Whole-frame records on the SETTLE_CYCLES=1 instance, ready tied high.
    // The mask input is inverted during the frame; the latched copy rules.
    for (int v = 0; v < 6; v++) begin
      drainIdle();
      applyStimulus(1'b1, vecs[v].mask, 1'b1);
      rel = 0; cnt = 0; sum = 0; first = -1; last = -1;
      while (!done[0] && rel < 100) begin
        if (valid[0]) begin
          cnt++;
          sum += int'(chan[0]);
          if (first < 0) first = int'(chan[0]);
          last = int'(chan[0]);
        end
        if (busy[0]) compareValue("selectEnabled", 0, int'(vecs[v].mask[sel[0]]), 1);
        applyStimulus(1'b0, ~vecs[v].mask, 1'b1);
        rel++;
      end
      compareValue("frameDoneEdge", 0, rel,   vecs[v].expDoneEdge);
      compareValue("frameCount",    0, cnt,   vecs[v].expCount);
      compareValue("frameChanSum",  0, sum,   vecs[v].expSum);
      compareValue("frameFirst",    0, first, vecs[v].expFirst);
      compareValue("frameLast",     0, last,  vecs[v].expLast);
    end

    // Backpressure on channel 3 of the SETTLE_CYCLES=3 instance.
    drainIdle();
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    n = 0;
    while (!(valid[1] && chan[1] == 4'd3) && n < 200) begin
      applyStimulus(1'b0, 16'hFFFF, 1'b1);
      n++;
    end
    compareValue("bpReachCh3", 1, int'(valid[1] && chan[1] == 4'd3), 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 16'hFFFF, 1'b0);
      compareValue("bpData",    1, int'(data[1]),  'h3333);
      compareValue("bpChannel", 1, int'(chan[1]),  3);
      compareValue("bpSelect",  1, int'(sel[1]),   3);
      compareValue("bpValid",   1, int'(valid[1]), 1);
    end
    applyStimulus(1'b0, 16'hFFFF, 1'b1);
    compareValue("bpAfterValid",  1, int'(valid[1]), 0);
    compareValue("bpAfterSelect", 1, int'(sel[1]),   4);
    n = 0;
    while (!valid[1] && n < 20) begin
      applyStimulus(1'b0, 16'hFFFF, 1'b1);
      n++;
    end
    compareValue("bpNextLatency", 1, n, 3);
    compareValue("bpNextChannel", 1, int'(chan[1]), 4);

    // Second tick four cycles into a frame is dropped with one overrun pulse.
    drainIdle();
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    rel = 0; cnt = 0; ovCount = 0;
    while (!done[0] && rel < 100) begin
      if (valid[0]) cnt++;
      applyStimulus(rel == 3, 16'hFFFF, 1'b1);
      rel++;
      if (overrun[0]) ovCount++;
    end
    compareValue("ovPulses",    0, ovCount, 1);
    compareValue("ovTransfers", 0, cnt,     16);
    compareValue("ovDoneEdge",  0, rel,     32);
    // A tick in the frame-done cycle starts a new frame.
    applyStimulus(1'b1, 16'h0003, 1'b1);
    compareValue("tickOnDoneBusy",    0, int'(busy[0]),    1);
    compareValue("tickOnDoneOverrun", 0, int'(overrun[0]), 0);

    // Reset during SETTLE of channel 6, then a fresh frame from channel 6.
    drainIdle();
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    n = 0;
    while (!(busy[1] && !valid[1] && sel[1] == 4'd6) && n < 200) begin
      applyStimulus(1'b0, 16'hFFFF, 1'b1);
      n++;
    end
    compareValue("rstReachCh6", 1, int'(sel[1]), 6);
    assertReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'hFFFF, 1'b1);
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'hFFFF, 1'b1);
    applyStimulus(1'b1, 16'h00C0, 1'b1);
    n = 0;
    while (!valid[1] && n < 20) begin
      applyStimulus(1'b0, 16'h0000, 1'b1);
      n++;
    end
    compareValue("rstRestartChannel", 1, int'(chan[1]), 6);
    compareValue("rstRestartData",    1, int'(data[1]), 'h6666);
    drainIdle();

    // Randomized traffic: ticks, masks of several shapes, random ready,
    // occasional asynchronous reset.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        assertReset();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b1, 16'hFFFF, 1'b1);
        rstN = 1'b1;
      end else begin
        case ($urandom_range(0, 3))
          0:       rmask = 16'h0000;
          1:       rmask = 16'($urandom);
          2:       rmask = 16'h0001 << $urandom_range(0, 15);
          default: rmask = 16'($urandom) & 16'($urandom);
        endcase
        applyStimulus(1'($urandom_range(0, 11) == 0), rmask, 1'($urandom_range(0, 9) < 7));
      end
    end
    drainIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
